// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a one-byte holding register
// with a valid/ready handshake, plus frame-error and overrun pulses.
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned BAUD_TICK_COUNT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_TICK       = BAUD_TICK_COUNT / 2;
  localparam logic [15:0] BitEnd          = 16'(BAUD_TICK_COUNT - 1);
  localparam logic [15:0] HalfEnd         = 16'(HALF_TICK - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e      state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        rx_meta;
  logic        rx_s;
  logic        line_break;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      cnt        <= 16'd0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      line_break <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_busy    <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      case (state)
        StIdle: begin
          cnt <= cnt + 16'd1;
          // After a frame error the line must be seen high before a new start is accepted.
          if (rx_s) begin
            line_break <= 1'b0;
          end else if (!line_break) begin
            state   <= StStart;
            cnt     <= 16'd0;
            rx_busy <= 1'b1;
          end
        end
        StStart: begin
          if (cnt == HalfEnd) begin
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            if (!rx_s) begin
              state <= StData;
            end else begin
              state   <= StIdle;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        StData: begin
          if (cnt == BitEnd) begin
            cnt     <= 16'd0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= StStop;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        StStop: begin
          // Leave mid-stop-bit so a back-to-back start edge is seen in time.
          if (cnt == BitEnd) begin
            cnt     <= 16'd0;
            state   <= StIdle;
            rx_busy <= 1'b0;
            if (rx_s) begin
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err  <= 1'b1;
              line_break <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state   <= StIdle;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a timeline model (per-cycle busy map and delivery events derived from the
// frames sent) is compared against the DUT every cycle, plus literal spot checks.
module tb_uart_rx;

  localparam int Bt       = 16;
  localparam int Ht       = 8;
  localparam int Lat      = 3 + Ht + 9 * Bt;
  localparam int N        = 8192;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_FREQ (16),
    .BAUD_RATE(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_busy  (rx_busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Timeline model: 0 none, 1 good byte delivered, 2 frame error, at a given edge number.
  logic [1:0] ev_kind [N];
  logic [7:0] ev_byte [N];
  bit         busy_at [N];

  logic       exp_valid = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic       exp_ferr = 1'b0;
  logic       exp_ovr = 1'b0;
  logic       exp_busy = 1'b0;

  int  rise_cyc = -1;
  int  ferr_cnt = 0;
  int  ovr_cnt = 0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    if (reset) begin
      exp_valid = 1'b0;
      exp_data  = 8'h00;
      exp_busy  = 1'b0;
      for (int i = cyc; i < N; i++) begin
        ev_kind[i] = 2'd0;
        busy_at[i] = 1'b0;
      end
    end else begin
      exp_busy = busy_at[cyc];
      if (ev_kind[cyc] == 2'd1) begin
        if (!exp_valid || rx_ready) begin
          exp_data  = ev_byte[cyc];
          exp_valid = 1'b1;
        end else begin
          exp_ovr = 1'b1;
        end
      end else if (exp_valid && rx_ready) begin
        exp_valid = 1'b0;
      end
      if (ev_kind[cyc] == 2'd2) exp_ferr = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("rx_valid", {31'd0, rx_valid}, {31'd0, exp_valid});
      chk("rx_data", {24'd0, rx_data}, {24'd0, exp_data});
      chk("rx_busy", {31'd0, rx_busy}, {31'd0, exp_busy});
      chk("frame_err", {31'd0, frame_err}, {31'd0, exp_ferr});
      chk("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
      if (rx_valid === 1'b1 && prev_valid === 1'b0) rise_cyc = cyc;
      prev_valid = rx_valid;
      if (frame_err === 1'b1) ferr_cnt++;
      if (overrun === 1'b1) ovr_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives the first nbits bits of an 8N1 frame and records its expected effect.
  task automatic send(input logic [7:0] b, input logic stop, input int nbits);
    int k;
    logic [9:0] f;
    k = cyc;
    f = {stop, b, 1'b0};
    ev_kind[k + Lat] = stop ? 2'd1 : 2'd2;
    ev_byte[k + Lat] = b;
    for (int i = k + 3; i < k + Lat; i++) busy_at[i] = 1'b1;
    for (int j = 0; j < nbits; j++) begin
      rx = f[j];
      tick(Bt);
    end
  endtask

  initial begin
    int k0;
    int f0;
    for (int i = 0; i < N; i++) begin
      ev_kind[i] = 2'd0;
      ev_byte[i] = 8'h00;
      busy_at[i] = 1'b0;
    end
    tick(5);
    chk("reset_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_data", {24'd0, rx_data}, 32'd0);
    reset = 1'b0;
    tick(20);

    // 0xA5, good stop, consumer not ready
    k0 = cyc;
    send(8'hA5, 1'b1, 10);
    chk("a5_latency", rise_cyc - k0, 155);
    chk("a5_data", {24'd0, rx_data}, 32'h0000_00A5);
    chk("a5_valid", {31'd0, rx_valid}, 32'd1);
    tick(10);
    chk("a5_hold", {31'd0, rx_valid}, 32'd1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    chk("a5_drain", {31'd0, rx_valid}, 32'd0);

    // Start-bit glitch of 4 cycles
    k0 = cyc;
    for (int i = k0 + 3; i <= k0 + 10; i++) busy_at[i] = 1'b1;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(30);
    chk("glitch_busy", {31'd0, rx_busy}, 32'd0);
    chk("glitch_valid", {31'd0, rx_valid}, 32'd0);
    chk("glitch_ferr", ferr_cnt, 0);

    // 0x3C with bad stop, then line held low
    f0 = ferr_cnt;
    send(8'h3C, 1'b0, 10);
    tick(40);
    rx = 1'b1;
    tick(40);
    chk("ferr_once", ferr_cnt - f0, 1);
    chk("ferr_valid", {31'd0, rx_valid}, 32'd0);

    // Back-to-back 0x11, 0x22 with no consumer
    send(8'h11, 1'b1, 10);
    send(8'h22, 1'b1, 10);
    tick(5);
    chk("ovr_once", ovr_cnt, 1);
    chk("ovr_data", {24'd0, rx_data}, 32'h0000_0011);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(10);

    // Same again but consumer accepts in the delivery cycle of 0x22
    send(8'h11, 1'b1, 10);
    fork
      send(8'h22, 1'b1, 10);
      begin
        tick(Lat - 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    tick(5);
    chk("swap_data", {24'd0, rx_data}, 32'h0000_0022);
    chk("swap_valid", {31'd0, rx_valid}, 32'd1);
    chk("swap_no_ovr", ovr_cnt, 1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(10);

    // Reset during data bit 4 of 0xFF
    send(8'hFF, 1'b1, 5);
    rx = 1'b1;
    tick(8);
    reset = 1'b1;
    tick(3);
    chk("rst_busy", {31'd0, rx_busy}, 32'd0);
    chk("rst_data", {24'd0, rx_data}, 32'd0);
    reset = 1'b0;
    tick(20);

    // 0x5A with rx_ready pulsed while nothing is held
    fork
      send(8'h5A, 1'b1, 10);
      begin
        tick(60);
        rx_ready = 1'b1;
        tick(40);
        rx_ready = 1'b0;
      end
    join
    tick(5);
    chk("5a_data", {24'd0, rx_data}, 32'h0000_005A);
    chk("5a_valid", {31'd0, rx_valid}, 32'd1);
    chk("ferr_total", ferr_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, SHALL give the clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, SHALL give the serial bit rate; BAUD_TICK_COUNT = CLK_FREQ/BAUD_RATE (integer) and HALF_TICK = BAUD_TICK_COUNT/2.
REQ-003 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx  input  1  asynchronous serial line; idle high; frame = 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-006 rx_data  output  8  last accepted byte; SHALL be valid while rx_valid=1.
REQ-007 rx_valid  output  1  byte available; SHALL be held high until consumed.
REQ-008 rx_ready  input  1  consumer accept; transfer occurs on a cycle with rx_valid=1 and rx_ready=1.
REQ-009 rx_busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
REQ-011 overrun  output  1  one-cycle pulse: byte completed while the holding register was full and not drained that cycle.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer; both flops SHALL reset to 1. All decisions SHALL use the synchronized value (rx_s).
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP. A 16-bit baud counter SHALL clear to 0 on every state entry and increment once per cycle otherwise.
REQ-014 IDLE: when rx_s=0, the FSM SHALL go to START on the next cycle.
REQ-015 START: at counter = HALF_TICK-1, if rx_s=0 the FSM SHALL go to DATA; if rx_s=1 (glitch), it SHALL return to IDLE with no output activity.
REQ-016 DATA: at each counter = BAUD_TICK_COUNT-1, rx_s SHALL be shifted into the MSB of an 8-bit shift register (shift right) and the bit index (0..7) SHALL increment; after the 8th sample the FSM SHALL go to STOP.
REQ-017 STOP: at counter = BAUD_TICK_COUNT-1, rx_s SHALL be sampled and the FSM SHALL go to IDLE in the same cycle, i.e. mid-stop-bit, so a back-to-back start bit is not missed.
REQ-018 Stop sample = 1: the byte SHALL be delivered per REQ-020/021. Stop sample = 0: frame_err SHALL pulse for 1 cycle, the byte SHALL be discarded, and rx_data/rx_valid SHALL be unchanged.
REQ-019 After a stop-bit sample of 0, IDLE SHALL NOT start a new frame until rx_s has been observed high for at least 1 cycle (break/line-low protection).
REQ-020 Delivery with rx_valid=0, or with rx_valid=1 and rx_ready=1 in the same cycle: rx_data SHALL load the new byte and rx_valid SHALL be 1 on the next cycle.
REQ-021 Delivery with rx_valid=1 and rx_ready=0: overrun SHALL pulse for 1 cycle, the new byte SHALL be dropped, and rx_data SHALL keep the old byte.
REQ-022 A transfer (rx_valid & rx_ready) with no simultaneous delivery SHALL clear rx_valid on the next cycle; rx_data SHALL hold its value.
REQ-023 rx_ready SHALL be ignored while rx_valid=0.
REQ-024 Latency: rx_valid SHALL rise 3 + HALF_TICK + 9*BAUD_TICK_COUNT cycles (±1) after the rx falling edge of the start bit.

Reset
REQ-025 While reset=1: FSM = IDLE; counter, bit index and shift register = 0; rx_data = 0x00; rx_valid = 0; rx_busy = 0; frame_err = 0; overrun = 0; synchronizer = 1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no delivery and no pulse; after release, the FSM SHALL wait in IDLE for the next rx_s=0.

Verification (CLK_FREQ=16, BAUD_RATE=1: BAUD_TICK_COUNT=16, HALF_TICK=8)
REQ-027 Send 0xA5 with a valid stop bit, rx_ready=0 -> rx_valid rises ~155 cycles after the start edge, rx_data=0xA5, frame_err=0, rx_valid stays high; pulse rx_ready -> rx_valid=0 next cycle.
REQ-028 Pull rx low for 4 cycles, then high -> FSM returns to IDLE from START, rx_valid=0, rx_busy drops, no pulses.
REQ-029 Send 0x3C with stop bit=0 -> frame_err pulses for 1 cycle, rx_valid=0; hold rx low for 40 cycles, then idle -> no new frame until rx returns high.
REQ-030 Send 0x11, then 0x22 back-to-back with rx_ready=0 -> overrun pulses at the end of 0x22, rx_data=0x11; repeat with rx_ready=1 in the delivery cycle -> rx_data=0x22, rx_valid stays 1, no overrun.
REQ-031 Assert reset during data bit 4 of 0xFF -> all outputs take reset values; next frame 0x5A is received correctly.
